// File: rtl/change_payout_ctrl_if.sv
// Bundle between the vending FSM and the coin-change ejector sequencer.
// Optional spur_cnt signal is present only when CHANGE_SPUR_CNT_EN is defined.
interface change_payout_ctrl_if #(
    parameter int unsigned AMT_W = 4
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic             coin_sense;
    logic             clr_err;
    logic             sol_out;
    logic             busy;
    logic             done;
    logic             err;
    logic [AMT_W-1:0] paid;
    logic [AMT_W-1:0] remaining;
`ifdef CHANGE_SPUR_CNT_EN
    logic [3:0]       spur_cnt;
`endif

    modport master (
        output req_valid, req_amount, coin_sense, clr_err,
        input  req_ready, sol_out, busy, done, err, paid, remaining
`ifdef CHANGE_SPUR_CNT_EN
        , input spur_cnt
`endif
    );

    modport slave (
        input  req_valid, req_amount, coin_sense, clr_err,
        output req_ready, sol_out, busy, done, err, paid, remaining
`ifdef CHANGE_SPUR_CNT_EN
        , output spur_cnt
`endif
    );
endinterface

// File: rtl/change_payout_ctrl.sv
// Coin-change ejector sequencer: fires the solenoid per coin, confirms via sensor, retries, faults.
// Define CHANGE_SPUR_CNT_EN to add the saturating spurious-sense counter (spur_cnt).
module change_payout_ctrl #(
    parameter int unsigned AMT_W     = 4,
    parameter int unsigned PULSE_CYC = 10,
    parameter int unsigned GAP_CYC   = 10,
    parameter int unsigned TMO_CYC   = 50,
    parameter int unsigned MAX_RETRY = 2
) (
    input logic                 clk,
    input logic                 rst,
    change_payout_ctrl_if.slave bus
);
    localparam int unsigned MAX_PG = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int unsigned MAX_T  = (MAX_PG > TMO_CYC) ? MAX_PG : TMO_CYC;
    localparam int unsigned TW     = $clog2(MAX_T + 1);
    localparam int unsigned RW     = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {StIdle, StFire, StWait, StGap, StDone, StFault} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             hit_q, hit_d;
    logic [AMT_W-1:0] paid_q, paid_d;
    logic [AMT_W-1:0] rem_q, rem_d;
    logic             sol_q, sol_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             prev_sense_q;
    logic             sense_edge;
    logic             spur_evt;

    assign sense_edge = bus.coin_sense & ~prev_sense_q;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        hit_d    = hit_q;
        paid_d   = paid_q;
        rem_d    = rem_q;
        sol_d    = sol_q;
        done_d   = 1'b0;
        err_d    = err_q;
        spur_evt = 1'b0;
        unique case (state_q)
            StIdle: begin
                spur_evt = sense_edge;
                if (bus.req_valid) begin
                    paid_d  = '0;
                    retry_d = '0;
                    hit_d   = 1'b0;
                    rem_d   = bus.req_amount;
                    if (bus.req_amount == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFire;
                        timer_d = TW'(PULSE_CYC);
                        sol_d   = 1'b1;
                    end
                end
            end
            StFire: begin
                timer_d = timer_q - TW'(1);
                // Only one coin is credited per pulse so paid+remaining cannot wrap.
                if (sense_edge && !hit_q) begin
                    hit_d   = 1'b1;
                    paid_d  = paid_q + AMT_W'(1);
                    rem_d   = rem_q - AMT_W'(1);
                    retry_d = '0;
                end
                if (timer_q == TW'(1)) begin
                    sol_d = 1'b0;
                    if (!hit_d) begin
                        state_d = StWait;
                        timer_d = TW'(TMO_CYC);
                    end else if (rem_d == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                        timer_d = TW'(GAP_CYC);
                    end
                end
            end
            StWait: begin
                timer_d = timer_q - TW'(1);
                if (sense_edge) begin
                    // A coin arriving on the expiry cycle still counts; no retry is charged.
                    paid_d  = paid_q + AMT_W'(1);
                    rem_d   = rem_q - AMT_W'(1);
                    retry_d = '0;
                    if (rem_d == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StGap;
                        timer_d = TW'(GAP_CYC);
                    end
                end else if (timer_q == TW'(1)) begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        state_d = StGap;
                        timer_d = TW'(GAP_CYC);
                    end else begin
                        state_d = StFault;
                        err_d   = 1'b1;
                    end
                end
            end
            StGap: begin
                spur_evt = sense_edge;
                timer_d  = timer_q - TW'(1);
                if (timer_q == TW'(1)) begin
                    state_d = StFire;
                    timer_d = TW'(PULSE_CYC);
                    sol_d   = 1'b1;
                    hit_d   = 1'b0;
                end
            end
            StDone: begin
                spur_evt = sense_edge;
                state_d  = StIdle;
            end
            StFault: begin
                spur_evt = sense_edge;
                if (bus.clr_err) begin
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            retry_q      <= '0;
            hit_q        <= 1'b0;
            paid_q       <= '0;
            rem_q        <= '0;
            sol_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            prev_sense_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            hit_q        <= hit_d;
            paid_q       <= paid_d;
            rem_q        <= rem_d;
            sol_q        <= sol_d;
            done_q       <= done_d;
            err_q        <= err_d;
            prev_sense_q <= bus.coin_sense;
        end
    end

`ifdef CHANGE_SPUR_CNT_EN
    logic [3:0] spur_q, spur_d;

    always_comb begin
        spur_d = spur_q;
        if (state_q == StFault && bus.clr_err) begin
            spur_d = '0;
        end else if (spur_evt && spur_q != 4'd15) begin
            spur_d = spur_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spur_q <= '0;
        end else begin
            spur_q <= spur_d;
        end
    end

    assign bus.spur_cnt = spur_q;
`else
    logic unused_spur;
    assign unused_spur = spur_evt;
`endif

    assign bus.req_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.sol_out   = sol_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.paid      = paid_q;
    assign bus.remaining = rem_q;
endmodule

// File: tb/tb_change_payout_ctrl.sv
// Directed self-checking bench for change_payout_ctrl (default parameters).
// Covers spur_cnt too when CHANGE_SPUR_CNT_EN is defined.
module tb_change_payout_ctrl;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n;

    change_payout_ctrl_if #(.AMT_W(4)) bus ();

    change_payout_ctrl #(
        .AMT_W    (4),
        .PULSE_CYC(10),
        .GAP_CYC  (10),
        .TMO_CYC  (50),
        .MAX_RETRY(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic accept(input logic [3:0] amt);
        chk("accept_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_amount = amt;
        @(negedge clk);
        bus.req_valid  = 1'b0;
    endtask

    task automatic count_high(output int cnt);
        cnt = 0;
        while (bus.sol_out === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic count_low(output int cnt);
        cnt = 0;
        while (bus.sol_out === 1'b0 && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    // From the first FIRE cycle with no sensing: 1 pulse + 2 retries, then FAULT and clear.
    task automatic retry_to_fault(input string tag, input int exp_paid, input int exp_rem);
        int c;
        for (int k = 0; k < 3; k++) begin
            count_high(c);
            chk({tag, "_pulse"}, 32'(c), 32'd10);
            if (k < 2) begin
                count_low(c);
                chk({tag, "_wait_gap"}, 32'(c), 32'd60);
            end
        end
        repeat (49) @(negedge clk);
        chk({tag, "_err_pre"}, 32'(bus.err), 32'd0);
        @(negedge clk);
        chk({tag, "_err"}, 32'(bus.err), 32'd1);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_paid"}, 32'(bus.paid), 32'(exp_paid));
        chk({tag, "_rem"}, 32'(bus.remaining), 32'(exp_rem));
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, 32'(bus.err), 32'd1);
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        chk({tag, "_clr_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_clr_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst            = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_amount = '0;
        bus.coin_sense = 1'b0;
        bus.clr_err    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sol", 32'(bus.sol_out), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_paid", 32'(bus.paid), 32'd0);
        chk("rst_rem", 32'(bus.remaining), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // 1: three coins, each sensed on WAIT cycle 5
        accept(4'd3);
        chk("t1_sol_first", 32'(bus.sol_out), 32'd1);
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_rem_start", 32'(bus.remaining), 32'd3);
        for (int k = 0; k < 3; k++) begin
            count_high(n);
            chk("t1_pulse", 32'(n), 32'd10);
            repeat (4) @(negedge clk);
            bus.coin_sense = 1'b1;
            @(negedge clk);
            bus.coin_sense = 1'b0;
            chk("t1_paid_step", 32'(bus.paid), 32'(k + 1));
            if (k < 2) begin
                chk("t1_no_done", 32'(bus.done), 32'd0);
                count_low(n);
                chk("t1_gap", 32'(n), 32'd10);
            end
        end
        chk("t1_done", 32'(bus.done), 32'd1);
        chk("t1_paid", 32'(bus.paid), 32'd3);
        chk("t1_rem", 32'(bus.remaining), 32'd0);
        chk("t1_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        chk("t1_done_once", 32'(bus.done), 32'd0);
        chk("t1_idle", 32'(bus.req_ready), 32'd1);
        chk("t1_paid_hold", 32'(bus.paid), 32'd3);

        // 2: zero amount
        accept(4'd0);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_sol", 32'(bus.sol_out), 32'd0);
        chk("t2_paid", 32'(bus.paid), 32'd0);
        @(negedge clk);
        chk("t2_done_once", 32'(bus.done), 32'd0);
        chk("t2_idle", 32'(bus.req_ready), 32'd1);

        // 3: no sensing at all -> fault after two retries
        accept(4'd2);
        retry_to_fault("t3", 0, 2);

        // 4: edge mid-pulse; pulse completes, no WAIT
        accept(4'd1);
        repeat (3) @(negedge clk);
        bus.coin_sense = 1'b1;
        @(negedge clk);
        bus.coin_sense = 1'b0;
        chk("t4_paid_early", 32'(bus.paid), 32'd1);
        count_high(n);
        chk("t4_rest_of_pulse", 32'(n), 32'd6);
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_rem", 32'(bus.remaining), 32'd0);
        @(negedge clk);
        chk("t4_idle", 32'(bus.req_ready), 32'd1);

        // 5: async reset during FIRE
        accept(4'd2);
        repeat (2) @(negedge clk);
        chk("t5_sol_pre", 32'(bus.sol_out), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("t5_sol_async", 32'(bus.sol_out), 32'd0);
        chk("t5_rem", 32'(bus.remaining), 32'd0);
        chk("t5_ready", 32'(bus.req_ready), 32'd1);
        chk("t5_err", 32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        accept(4'd1);
        chk("t5_refire", 32'(bus.sol_out), 32'd1);
        chk("t5_rem_new", 32'(bus.remaining), 32'd1);
        count_high(n);
        chk("t5_pulse", 32'(n), 32'd10);
        bus.coin_sense = 1'b1;
        @(negedge clk);
        bus.coin_sense = 1'b0;
        chk("t5_done", 32'(bus.done), 32'd1);
        chk("t5_paid", 32'(bus.paid), 32'd1);
        @(negedge clk);

        // 6: edge on the WAIT expiry cycle wins, retry count stays clear
        accept(4'd2);
        count_high(n);
        chk("t6_pulse", 32'(n), 32'd10);
        repeat (49) @(negedge clk);
        bus.coin_sense = 1'b1;
        @(negedge clk);
        bus.coin_sense = 1'b0;
        chk("t6_paid", 32'(bus.paid), 32'd1);
        chk("t6_rem", 32'(bus.remaining), 32'd1);
        chk("t6_err", 32'(bus.err), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd1);
        count_low(n);
        chk("t6_gap", 32'(n), 32'd10);
        retry_to_fault("t6", 1, 1);

`ifdef CHANGE_SPUR_CNT_EN
        chk("t6_spur_clr", 32'(bus.spur_cnt), 32'd0);
        repeat (20) begin
            bus.coin_sense = 1'b1;
            @(negedge clk);
            bus.coin_sense = 1'b0;
            @(negedge clk);
        end
        chk("t6_spur_sat", 32'(bus.spur_cnt), 32'd15);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/change_payout_ctrl.md
Name: change_payout_ctrl

Overview:
Sequencer for the coin-change ejector solenoid. Accepts a change amount from the vending FSM over a valid/ready handshake. Fires the solenoid once per coin and confirms each coin with the ejected-coin sensor, retrying on a missed coin and latching a fault when retries run out. Sits between the vending FSM's change register and the physical ejector.

Parameters:
AMT_W, 4, width of amount/paid/remaining
PULSE_CYC, 10, solenoid on-time in clk cycles (>=1)
GAP_CYC, 10, solenoid off-time between pulses (>=1)
TMO_CYC, 50, sense-wait timeout in cycles (>=1)
MAX_RETRY, 2, re-fires allowed per coin before fault

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  change request valid
req_amount  in  AMT_W  coins to pay out
req_ready  out  1  controller can accept request
coin_sense  in  1  ejected-coin detector level, synchronous to clk
clr_err  in  1  clears fault, returns to IDLE
sol_out  out  1  solenoid drive
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse: payout complete
err  out  1  fault flag
paid  out  AMT_W  coins confirmed this request
remaining  out  AMT_W  coins still owed

Behaviour:
- Reset (rst=0, async): state=IDLE, sol_out=0, done=0, err=0, paid=0, remaining=0, all timers/retry=0, sense edge register=0. Reset mid-operation drops sol_out immediately; the in-flight request is lost.
- Sense edge = coin_sense & ~prev_sense; prev_sense is registered every cycle.
- All outputs are registered except req_ready (=state==IDLE) and busy (=state!=IDLE).
- IDLE: accept on req_valid&req_ready. On acceptance, paid<=0 and retry<=0.
  - Amount 0: go to DONE.
  - Otherwise: remaining<=amount, timer<=PULSE_CYC, go to FIRE.
- FIRE: sol_out=1 for exactly PULSE_CYC cycles, then sol_out=0.
  - Sense edge during FIRE counts as a coin (paid+1, remaining-1, retry<=0). The pulse still completes. Afterwards go to DONE if remaining==0, else GAP; WAIT is skipped.
  - No edge during FIRE: go to WAIT with timer<=TMO_CYC.
- WAIT: sol_out=0.
  - Sense edge: count the coin, then go to DONE if remaining becomes 0, else GAP.
  - Timer expiry without an edge: if retry<MAX_RETRY, retry+1 and go to GAP (the same coin is re-fired, nothing is decremented). Otherwise go to FAULT.
  - Edge and expiry in the same cycle: the edge wins and no retry is counted.
- GAP: sol_out=0 for GAP_CYC cycles, then go to FIRE.
- DONE: done=1 for exactly one cycle, then go to IDLE. paid/remaining hold until the next acceptance.
- FAULT: err=1, sol_out=0, req_ready=0. Stays in FAULT until clr_err=1, then err<=0 and go to IDLE. clr_err is ignored in every other state.
- Sense edges in IDLE, GAP, DONE and FAULT are ignored for counting.
- paid+remaining always equals the accepted amount; no wrap is possible.
- Timer width = $clog2(max(PULSE_CYC,GAP_CYC,TMO_CYC)+1). Retry width = $clog2(MAX_RETRY+1).
- Latency: acceptance to first sol_out high = 1 cycle. Amount 0: acceptance to done = 1 cycle.

Optional Feature:
CHANGE_SPUR_CNT_EN
- Defined: adds output spur_cnt[3:0], a saturating count (stops at 15) of sense edges ignored in IDLE, GAP, DONE and FAULT. Resets to 0 on rst and on clr_err. It is not cleared by request acceptance.
- Undefined: port and counter are absent. Behaviour is otherwise identical.

Test Plan:
1. amount=3, sense edge 5 cycles into each WAIT -> three sol_out pulses of 10 cycles each, separated by 10-cycle gaps; single done pulse; paid=3, remaining=0, err=0.
2. amount=0 -> done high exactly 1 cycle after acceptance; sol_out never high; paid=0.
3. amount=2, coin_sense held 0 -> three 10-cycle pulses (1 initial + 2 retries), each followed by a 50-cycle WAIT; FAULT after the third timeout with err=1, req_ready=0, paid=0, remaining=2. clr_err pulse -> IDLE, err=0, req_ready=1.
4. amount=1, sense edge on FIRE cycle 4 -> sol_out stays high the full 10 cycles, then done with no WAIT; paid=1.
5. amount=2, rst asserted on FIRE cycle 3 -> sol_out=0 asynchronously, all outputs at reset values. New request after rst release is accepted normally.
6. Sense edge on the exact cycle the WAIT timer expires -> coin counted, retry stays 0, no FAULT. With CHANGE_SPUR_CNT_EN defined, 20 edges in IDLE -> spur_cnt=15.
